// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath widths and reset vector shared by the pipeline stages.
package cpu_pkg;

   localparam int unsigned PC_W   = 32;
   localparam int unsigned INST_W = 32;

   typedef logic [PC_W-1:0]   pc_t;
   typedef logic [INST_W-1:0] inst_t;

   localparam pc_t RESET_PC_DEFAULT = 32'h1c00_0000;
   localparam pc_t PC_STEP          = 32'd4;

endpackage

// File: rtl/if_inst_buf.sv
// if_inst_buf: keeps the SRAM word seen in the first stalled cycle so decode
// sees a stable instruction even if the SRAM output changes while stalled.
module if_inst_buf
   import cpu_pkg::*;
(
   input  logic  clk,
   input  logic  resetn,
   input  logic  capture,
   input  logic  clear,
   input  inst_t rdata,
   output inst_t inst
);

   logic  buf_valid_q, buf_valid_d;
   inst_t buf_data_q, buf_data_d;

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      if (clear) begin
         buf_valid_d = 1'b0;
      end else if (capture && !buf_valid_q) begin
         buf_valid_d = 1'b1;
         buf_data_d  = rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         buf_valid_q <= 1'b0;
         buf_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
      end
   end

   assign inst = buf_valid_q ? buf_data_q : rdata;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with one-cycle SRAM latency and branch redirect.
// Define IF_INST_BUF_EN to hold the fetched word in a buffer across decode stalls.
module if_stage
   import cpu_pkg::*;
#(
   parameter pc_t RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic              clk,
   input  logic              resetn,
   output logic              inst_sram_en,
   output logic              inst_sram_we,
   output logic [PC_W-1:0]   inst_sram_addr,
   output logic [INST_W-1:0] inst_sram_wdata,
   input  logic [INST_W-1:0] inst_sram_rdata,
   input  logic              br_taken,
   input  logic [PC_W-1:0]   br_target,
   input  logic              ds_allowin,
   output logic              fs_to_ds_valid,
   output logic [PC_W-1:0]   fs_to_ds_pc,
   output logic [INST_W-1:0] fs_to_ds_inst
);

   pc_t  fs_pc_q, fs_pc_d;
   logic fs_valid_q, fs_valid_d;
   pc_t  nextpc;
   logic fs_allowin;
   logic transfer;

   assign nextpc     = br_taken ? br_target : fs_pc_q + PC_STEP;
   assign fs_allowin = !fs_valid_q || ds_allowin || br_taken;

   always_comb begin
      fs_pc_d    = fs_pc_q;
      fs_valid_d = fs_valid_q;
      if (fs_allowin) begin
         fs_pc_d    = nextpc;
         fs_valid_d = 1'b1;
      end
   end

   // Reset parks the PC one step before the vector so nextpc lands on RESET_PC.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         fs_pc_q    <= RESET_PC - PC_STEP;
         fs_valid_q <= 1'b0;
      end else begin
         fs_pc_q    <= fs_pc_d;
         fs_valid_q <= fs_valid_d;
      end
   end

   assign inst_sram_en    = resetn && fs_allowin;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_wdata = '0;

   assign fs_to_ds_valid = resetn && fs_valid_q && !br_taken;
   assign fs_to_ds_pc    = fs_pc_q;
   assign transfer       = fs_to_ds_valid && ds_allowin;

`ifdef IF_INST_BUF_EN
   if_inst_buf u_inst_buf (
      .clk     (clk),
      .resetn  (resetn),
      .capture (fs_valid_q && !ds_allowin && !br_taken),
      .clear   (transfer || br_taken),
      .rdata   (inst_sram_rdata),
      .inst    (fs_to_ds_inst)
   );
`else
   assign fs_to_ds_inst = inst_sram_rdata;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch sequencing, stalls, redirects and reset.
// Build with +define+IF_INST_BUF_EN to also exercise the stall buffer.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_en, inst_sram_we;
   logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
   logic        br_taken;
   logic [31:0] br_target;
   logic        ds_allowin;
   logic        fs_to_ds_valid;
   logic [31:0] fs_to_ds_pc, fs_to_ds_inst;
   logic        corrupt;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   if_stage #(.RESET_PC(32'h1c00_0000)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .br_taken        (br_taken),
      .br_target       (br_target),
      .ds_allowin      (ds_allowin),
      .fs_to_ds_valid  (fs_to_ds_valid),
      .fs_to_ds_pc     (fs_to_ds_pc),
      .fs_to_ds_inst   (fs_to_ds_inst)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5a5a_a5a5;
   endfunction

   // Synchronous SRAM: one-cycle read latency, output held while not enabled.
   always @(posedge clk) begin
      if (corrupt)
         inst_sram_rdata <= 32'hdead_beef;
      else if (inst_sram_en)
         inst_sram_rdata <= inst_of(inst_sram_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_offer(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, {31'd0, fs_to_ds_valid}, 32'd1);
      check({tag, "_pc"}, fs_to_ds_pc, pc);
      check({tag, "_inst"}, fs_to_ds_inst, inst_of(pc));
   endtask

   initial begin
      resetn     = 1'b0;
      ds_allowin = 1'b1;
      br_taken   = 1'b0;
      br_target  = '0;
      corrupt    = 1'b0;
      inst_sram_rdata = '0;
      tick();
      tick();

      check("rst_en", {31'd0, inst_sram_en}, 32'd0);
      check("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
      check("rst_addr", inst_sram_addr, 32'h1c00_0000);
      check("tied_we", {31'd0, inst_sram_we}, 32'd0);
      check("tied_wdata", inst_sram_wdata, 32'd0);

      resetn = 1'b1;
      #1;
      check("rel_en", {31'd0, inst_sram_en}, 32'd1);
      check("rel_addr", inst_sram_addr, 32'h1c00_0000);
      tick();
      check_offer("seq0", 32'h1c00_0000);
      check("seq0_addr", inst_sram_addr, 32'h1c00_0004);
      tick();
      check_offer("seq1", 32'h1c00_0004);
      tick();
      check_offer("seq2", 32'h1c00_0008);

      // Three-cycle decode stall at 0x...08.
      ds_allowin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_en", {31'd0, inst_sram_en}, 32'd0);
         check("stall_addr", inst_sram_addr, 32'h1c00_000c);
         check_offer("stall", 32'h1c00_0008);
         if (i < 2) tick();
      end
      ds_allowin = 1'b1;
      #1;
      check("unstall_en", {31'd0, inst_sram_en}, 32'd1);
      tick();
      check_offer("after_stall", 32'h1c00_000c);
      tick();
      check_offer("pre_br", 32'h1c00_0010);

      // Redirect while 0x...10 sits in IF: it is cancelled.
      br_taken  = 1'b1;
      br_target = 32'h1c00_0100;
      #1;
      check("br_valid", {31'd0, fs_to_ds_valid}, 32'd0);
      check("br_en", {31'd0, inst_sram_en}, 32'd1);
      check("br_addr", inst_sram_addr, 32'h1c00_0100);
      tick();
      br_taken = 1'b0;
      #1;
      check_offer("br_tgt", 32'h1c00_0100);

      // Stall at 0x...100, then redirect while still stalled.
      ds_allowin = 1'b0;
      #1;
      check("bs_en", {31'd0, inst_sram_en}, 32'd0);
      tick();
      check_offer("bs_hold", 32'h1c00_0100);
      br_taken  = 1'b1;
      br_target = 32'h1c00_0200;
      #1;
      check("bs_br_en", {31'd0, inst_sram_en}, 32'd1);
      check("bs_br_addr", inst_sram_addr, 32'h1c00_0200);
      check("bs_br_valid", {31'd0, fs_to_ds_valid}, 32'd0);
      tick();
      br_taken = 1'b0;
      #1;
      check_offer("bs_tgt", 32'h1c00_0200);

      // Stall at 0x...200; with the buffer, SRAM output is trashed meanwhile.
      tick();
      check_offer("bs_stall_a", 32'h1c00_0200);
`ifdef IF_INST_BUF_EN
      corrupt = 1'b1;
`endif
      tick();
      corrupt = 1'b0;
      check_offer("buf_hold", 32'h1c00_0200);
      tick();
      check_offer("buf_hold2", 32'h1c00_0200);
      ds_allowin = 1'b1;
      #1;
      check("buf_rel_addr", inst_sram_addr, 32'h1c00_0204);
      tick();
      check_offer("buf_next", 32'h1c00_0204);

      // One-cycle reset mid-stream.
      resetn = 1'b0;
      #1;
      check("mid_rst_en", {31'd0, inst_sram_en}, 32'd0);
      check("mid_rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
      tick();
      resetn = 1'b1;
      #1;
      check("post_rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
      check("post_rst_addr", inst_sram_addr, 32'h1c00_0000);
      check("post_rst_en", {31'd0, inst_sram_en}, 32'd1);
      tick();
      check_offer("restart0", 32'h1c00_0000);
      tick();
      check_offer("restart1", 32'h1c00_0004);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Fixed-length stimulus; this only guards against an unexpected hang.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1);
   end

endmodule
